prf_wb_arbiter: RTL and testbench
=================================

Name: prf_wb_arbiter

Overview:
- Shares the PRF write ports between the writeback outputs of REQ_COUNT execution pipelines (ALU pipelines and peers).
- Each PRF bank accepts one write per cycle. The arbiter grants one requester per bank per cycle using per-bank round-robin.
- It returns same-cycle WB_ready backpressure to each pipeline, and registers the winning writes for the PRF bank write ports, the forward network and the ROB complete ports.

Parameters:
- REQ_COUNT, 4, number of writeback requesters (any value >= 2, need not be a power of two).
- PRF_BANK_COUNT, 4, number of PRF banks (power of two); LOG_PRF_BANK_COUNT is derived.
- LOG_PR_COUNT, 7, physical register index width.
- LOG_ROB_ENTRIES, 7, ROB index width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous, active-high reset (asserted = 1).
- req_WB_valid  in  [REQ_COUNT]  requester has a writeback.
- req_WB_data  in  [REQ_COUNT][32]  writeback data.
- req_WB_PR  in  [REQ_COUNT][LOG_PR_COUNT]  destination PR; bank = PR[LOG_PRF_BANK_COUNT-1:0].
- req_WB_ROB_index  in  [REQ_COUNT][LOG_ROB_ENTRIES]  ROB entry to complete.
- req_WB_ready  out  [REQ_COUNT]  combinational grant; a request is accepted in the cycle where valid & ready.
- write_valid_by_bank  out  [PRF_BANK_COUNT]  registered PRF write enable.
- write_PR_by_bank  out  [PRF_BANK_COUNT][LOG_PR_COUNT]  registered write PR.
- write_data_by_bank  out  [PRF_BANK_COUNT][32]  registered write data; also drives forward_data_by_bank.
- complete_valid_by_bank  out  [PRF_BANK_COUNT]  registered ROB complete strobe.
- complete_ROB_index_by_bank  out  [PRF_BANK_COUNT][LOG_ROB_ENTRIES]  registered ROB index.

Behaviour:
- Bank decode: requester i targets bank b when req_WB_valid[i] is 1 and req_WB_PR[i][LOG_PRF_BANK_COUNT-1:0] equals b. Invalid requesters target nothing.
- Per-bank arbitration, each cycle:
  - Scan requesters starting at rr_ptr[b] and wrapping modulo REQ_COUNT.
  - The first requester targeting b wins.
  - At most one grant per bank and at most one grant per requester.
- req_WB_ready[i] = 1 only if requester i is granted this cycle. It is 0 when req_WB_valid[i] = 0, and 0 while nRST = 1.
- Requesters must hold valid and payload stable until accepted (matches a pipeline WB-stage stall). The arbiter does not rely on this for correctness.
- Pointer update: on a grant to requester i on bank b, rr_ptr[b] <= (i+1) mod REQ_COUNT. Wrap is explicit: i = REQ_COUNT-1 gives 0. With no grant, rr_ptr[b] holds.
- Output stage, one-cycle latency: on the edge after acceptance,
  - write_valid_by_bank[b] = 1 and complete_valid_by_bank[b] = 1;
  - PR, data and ROB index are copied from the winning requester.
  - A bank with no grant drives valid = 0; its payload registers hold their previous value.
- Fairness: a requester held valid for a bank is granted within REQ_COUNT cycles, worst case REQ_COUNT-1 cycles of loss.
- Simultaneous events:
  - All requesters on one bank: exactly one grant, the others see ready = 0.
  - Requesters on distinct banks: all granted in the same cycle.
- No PRF write-port backpressure exists. The output stage never stalls, so throughput is 1 write per bank per cycle.
- Reset (synchronous, nRST = 1 at the edge):
  - rr_ptr[b] = 0 for all b.
  - All *_valid_by_bank outputs = 0; all payload outputs = 0.
  - req_WB_ready = 0 while reset is asserted.
  - Reset mid-stream discards any in-flight accepted write not yet driven. No write appears on the edge that samples reset.
- Out of scope: X0/PR 0 filtering is done upstream; the arbiter writes whatever PR it is given.

Decomposition:
- core_types_pkg provides PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT and LOG_ROB_ENTRIES. The module parameters default from these.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr;
  - outputs: one-hot gnt[N], gnt_index, any_gnt.
  - Instantiated once per bank; the pointer registers stay in prf_wb_arbiter.

Test Plan:
- Reset: hold nRST = 1 with all req valid -> req_WB_ready = 0000, all write/complete valids 0. After release, a req0 PR=0x05 (bank 1) data=0xDEADBEEF -> ready[0] = 1 the same cycle; next cycle write_valid_by_bank = 0010, write_data[1] = 0xDEADBEEF, complete_ROB_index[1] = req0 ROB index.
- Full conflict: req0..3 all PR bank 2, held valid -> grants rotate 0,1,2,3,0 over 5 cycles. Each requester sees ready exactly once per 4 cycles; write_valid_by_bank[2] = 1 every cycle.
- Parallel: req0→bank0, req1→bank1, req2→bank2, req3→bank3 in one cycle -> ready = 1111; next cycle write_valid_by_bank = 1111 with matching PRs and data.
- Pointer wrap and hold:
  - req3 alone on bank0 -> granted, rr_ptr[0] = 0.
  - Idle 3 cycles -> rr_ptr[0] still 0.
  - Then req0 and req3 both on bank0 -> req0 granted first.
- Backpressure into ALU pipeline: two alu_pipeline_v2 instances both writing bank 1 on back-to-back ops -> loser's WB stage holds WB_data stable one cycle and no data is lost or duplicated. The ROB sees each index complete exactly once.
- Mid-stream reset: grant req1 at cycle N, assert nRST at cycle N+1 edge -> write_valid_by_bank stays 0 and the pending write is not emitted; rr_ptr returns to 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// core_types_pkg
// Shared core sizing constants for the writeback path plus a small
// modulo-wrap helper used by the round-robin logic.
//   PRF_BANK_COUNT     : number of PRF banks (power of two)
//   LOG_PRF_BANK_COUNT : bank-select width, taken from the PR low bits
//   LOG_PR_COUNT       : physical register index width
//   LOG_ROB_ENTRIES    : ROB index width
//   WB_DATA_W          : writeback data width
package core_types_pkg;

  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 7;
  localparam int WB_DATA_W          = 32;

  // (base + off) mod n for base < n and off < n. Avoids a real divider,
  // so n does not have to be a power of two.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Single-resource round-robin arbiter. Scans req starting at ptr and
// wrapping modulo N; the first asserted request wins.
//   req       in  [N]        request vector
//   ptr       in  [LOG_N]    highest-priority index this cycle (< N)
//   gnt       out [N]        one-hot grant (all zero when nothing requests)
//   gnt_index out [LOG_N]    binary index of the granted request
//   any_gnt   out 1          some request was granted
// The priority pointer itself lives with the caller.
module rr_arbiter
  import core_types_pkg::*;
#(
  parameter int N     = 4,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [LOG_N-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [LOG_N-1:0] gnt_index,
  output logic             any_gnt
);

  logic [LOG_N-1:0] w_idx;

  // Walk the rotated order from lowest priority to highest so the last
  // hit, i.e. the one closest to ptr, overwrites everything before it.
  always_comb begin
    gnt       = '0;
    gnt_index = '0;
    any_gnt   = 1'b0;
    w_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = LOG_N'(rr_wrap(int'(ptr), k, N));
      if (req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        gnt_index  = w_idx;
        any_gnt    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter
// Shares the PRF bank write ports between REQ_COUNT writeback pipelines.
// Each bank takes one write per cycle; a per-bank round-robin picks the
// winner. Winners see a same-cycle ready; the winning write is registered
// one cycle later onto the bank write port, forward network and ROB
// complete port.
//   CLK                         in   clock
//   nRST                        in   synchronous reset, active high
//   req_WB_valid/data/PR/ROB_index  in   per-requester writeback
//   req_WB_ready                out  combinational accept (valid & granted)
//   write_valid_by_bank         out  registered PRF write enable
//   write_PR_by_bank            out  registered write PR
//   write_data_by_bank          out  registered write data (also forwarded)
//   complete_valid_by_bank      out  registered ROB complete strobe
//   complete_ROB_index_by_bank  out  registered ROB index
module prf_wb_arbiter #(
  parameter int REQ_COUNT       = 4,
  parameter int PRF_BANK_COUNT  = core_types_pkg::PRF_BANK_COUNT,
  parameter int LOG_PR_COUNT    = core_types_pkg::LOG_PR_COUNT,
  parameter int LOG_ROB_ENTRIES = core_types_pkg::LOG_ROB_ENTRIES
) (
  input  logic                                           CLK,
  input  logic                                           nRST,
  input  logic [REQ_COUNT-1:0]                           req_WB_valid,
  input  logic [REQ_COUNT-1:0][31:0]                     req_WB_data,
  input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]         req_WB_PR,
  input  logic [REQ_COUNT-1:0][LOG_ROB_ENTRIES-1:0]      req_WB_ROB_index,
  output logic [REQ_COUNT-1:0]                           req_WB_ready,
  output logic [PRF_BANK_COUNT-1:0]                      write_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    write_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][31:0]                write_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                      complete_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0] complete_ROB_index_by_bank
);
  import core_types_pkg::*;

  localparam int LOG_BANKS = $clog2(PRF_BANK_COUNT);
  localparam int LOG_REQ   = $clog2(REQ_COUNT);

  // Per-bank request/grant matrices, indexed [bank][requester].
  logic [PRF_BANK_COUNT-1:0][REQ_COUNT-1:0] w_req_by_bank;
  logic [PRF_BANK_COUNT-1:0][REQ_COUNT-1:0] w_gnt_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_REQ-1:0]   w_gnt_idx;
  logic [PRF_BANK_COUNT-1:0]                w_any_gnt;
  logic [REQ_COUNT-1:0]                     w_ready;

  logic [PRF_BANK_COUNT-1:0][LOG_REQ-1:0]         r_rr_ptr;
  logic [PRF_BANK_COUNT-1:0]                      r_wb_valid;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    r_wb_pr;
  logic [PRF_BANK_COUNT-1:0][31:0]                r_wb_data;
  logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0] r_wb_rob;

  // Bank decode: a valid requester targets exactly one bank, picked by the
  // PR low bits, so it can never win on two banks at once.
  always_comb begin
    w_req_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        w_req_by_bank[b][i] = req_WB_valid[i] &&
          (req_WB_PR[i][LOG_BANKS-1:0] == LOG_BANKS'(b));
      end
    end
  end

  generate
    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
      rr_arbiter #(
        .N     (REQ_COUNT),
        .LOG_N (LOG_REQ)
      ) u_rr (
        .req       (w_req_by_bank[gb]),
        .ptr       (r_rr_ptr[gb]),
        .gnt       (w_gnt_by_bank[gb]),
        .gnt_index (w_gnt_idx[gb]),
        .any_gnt   (w_any_gnt[gb])
      );
    end
  endgenerate

  // A requester is ready when any bank granted it. Nothing is accepted
  // while reset is held, so the arbiter's grant is masked off here too.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_ready = w_ready | w_gnt_by_bank[b];
    end
  end

  assign req_WB_ready = nRST ? '0 : w_ready;

  // Pointer update and output stage. Reset takes priority over any grant,
  // which drops a write accepted on the same edge.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= '0;
      r_wb_pr    <= '0;
      r_wb_data  <= '0;
      r_wb_rob   <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        r_wb_valid[b] <= w_any_gnt[b];
        if (w_any_gnt[b]) begin
          // Winner moves to lowest priority; i = REQ_COUNT-1 wraps to 0.
          r_rr_ptr[b]  <= LOG_REQ'(rr_wrap(int'(w_gnt_idx[b]), 1, REQ_COUNT));
          r_wb_pr[b]   <= req_WB_PR[w_gnt_idx[b]];
          r_wb_data[b] <= req_WB_data[w_gnt_idx[b]];
          r_wb_rob[b]  <= req_WB_ROB_index[w_gnt_idx[b]];
        end
      end
    end
  end

  assign write_valid_by_bank        = r_wb_valid;
  assign write_PR_by_bank           = r_wb_pr;
  assign write_data_by_bank         = r_wb_data;
  assign complete_valid_by_bank     = r_wb_valid;
  assign complete_ROB_index_by_bank = r_wb_rob;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
module tb_prf_wb_arbiter;
  localparam int R = 4;
  localparam int B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [R-1:0]         v;
  logic [R-1:0][31:0]   d;
  logic [R-1:0][6:0]    pr;
  logic [R-1:0][6:0]    rob;
  logic [R-1:0]         rdy;
  logic [B-1:0]         wv, cv;
  logic [B-1:0][6:0]    wpr, crob;
  logic [B-1:0][31:0]   wd;

  prf_wb_arbiter dut (
    .CLK                        (clk),
    .nRST                       (rst),
    .req_WB_valid               (v),
    .req_WB_data                (d),
    .req_WB_PR                  (pr),
    .req_WB_ROB_index           (rob),
    .req_WB_ready               (rdy),
    .write_valid_by_bank        (wv),
    .write_PR_by_bank           (wpr),
    .write_data_by_bank         (wd),
    .complete_valid_by_bank     (cv),
    .complete_ROB_index_by_bank (crob)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [B-1:0]       vld;
    logic [B-1:0][6:0]  pr;
    logic [B-1:0][31:0] data;
    logic [B-1:0][6:0]  rob;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         m_out, e, got;
  int           m_ptr[B];
  logic [R-1:0] m_rdy;

  // Reference arbitration: scan from the bank pointer, first hit wins.
  // Pushes the expected registered outputs for the coming edge.
  function automatic void model_push(input logic r);
    exp_t x;
    x     = m_out;
    x.vld = '0;
    m_rdy = '0;
    if (r) begin
      x = '0;
      for (int b = 0; b < B; b++) m_ptr[b] = 0;
    end else begin
      for (int b = 0; b < B; b++) begin
        for (int k = 0; k < R; k++) begin
          int i;
          i = (m_ptr[b] + k) % R;
          if (v[i] && (pr[i][1:0] == 2'(b))) begin
            x.vld[b]  = 1'b1;
            x.pr[b]   = pr[i];
            x.data[b] = d[i];
            x.rob[b]  = rob[i];
            m_rdy[i]  = 1'b1;
            m_ptr[b]  = (i + 1) % R;
            break;
          end
        end
      end
    end
    m_out = x;
    sb_q.push_back(x);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    v   = '1;
    for (int i = 0; i < R; i++) begin
      pr[i]  = 7'(i * 5);
      d[i]   = 32'h1111_0000 + i;
      rob[i] = 7'(i + 1);
    end
    repeat (2) begin
      #1; model_push(1'b1);
      n_cmp++;
      if (rdy !== 4'b0000) begin
        n_bad++; $display("FAIL reset_ready got %b exp 0000", rdy);
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
      n_cmp++;
      if (got !== e || cv !== 4'b0000 || wv !== 4'b0000) begin
        n_bad++; $display("FAIL reset_outputs got wv=%b cv=%b pr=%h exp zero", wv, cv, wpr);
      end
    end
    // first write after release: PR 0x05 -> bank 1
    rst = 1'b0;
    v = 4'b0001; pr[0] = 7'h05; d[0] = 32'hDEADBEEF; rob[0] = 7'h2A;
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_bad++; $display("FAIL first_ready got %b exp 0001", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (wv !== 4'b0010 || wd[1] !== 32'hDEADBEEF || crob[1] !== 7'h2A || wpr[1] !== 7'h05) begin
      n_bad++; $display("FAIL first_write got wv=%b data=%h rob=%h pr=%h exp 0010 deadbeef 2a 05",
                        wv, wd[1], crob[1], wpr[1]);
    end
    n_cmp++;
    if (got !== e || cv !== e.vld) begin
      n_bad++; $display("FAIL first_sb got %h exp %h", got, e);
    end
  endtask

  task automatic test_full_conflict();
    int ord[5] = '{0, 1, 2, 3, 0};
    int cnt[R] = '{0, 0, 0, 0};
    v = 4'b1111;
    for (int i = 0; i < R; i++) begin
      pr[i]  = 7'(i * 4 + 2);
      d[i]   = 32'hC0DE_0000 + i;
      rob[i] = 7'(16 + i);
    end
    for (int k = 0; k < 5; k++) begin
      #1; model_push(1'b0);
      n_cmp++;
      if (rdy !== (4'b0001 << ord[k])) begin
        n_bad++; $display("FAIL conflict_ready[%0d] got %b exp req%0d", k, rdy, ord[k]);
      end
      if (k < 4) for (int i = 0; i < R; i++) cnt[i] += int'(rdy[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
      n_cmp++;
      if (got !== e || cv !== e.vld || wv[2] !== 1'b1 || wd[2] !== d[ord[k]]) begin
        n_bad++; $display("FAIL conflict_write[%0d] got wv=%b data=%h exp bank2 data=%h",
                          k, wv, wd[2], d[ord[k]]);
      end
    end
    for (int i = 0; i < R; i++) begin
      n_cmp++;
      if (cnt[i] != 1) begin
        n_bad++; $display("FAIL conflict_fair req%0d got %0d grants exp 1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_parallel();
    v = 4'b1111;
    for (int i = 0; i < R; i++) begin
      pr[i]  = 7'(8 * i + i);
      d[i]   = $urandom;
      rob[i] = 7'(32 + i);
    end
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b1111) begin
      n_bad++; $display("FAIL parallel_ready got %b exp 1111", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (wv !== 4'b1111 || got !== e || cv !== 4'b1111) begin
      n_bad++; $display("FAIL parallel_write got wv=%b %h exp 1111 %h", wv, got, e);
    end
    for (int i = 0; i < R; i++) begin
      n_cmp++;
      if (wpr[i] !== pr[i] || wd[i] !== d[i]) begin
        n_bad++; $display("FAIL parallel_bank%0d got pr=%h data=%h exp pr=%h data=%h",
                          i, wpr[i], wd[i], pr[i], d[i]);
      end
    end
  endtask

  task automatic test_wrap();
    v = 4'b1000; pr[3] = 7'h40; d[3] = 32'h3333_0003; rob[3] = 7'h53;
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b1000) begin
      n_bad++; $display("FAIL wrap_req3 got %b exp 1000", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (got !== e || cv !== e.vld || wv !== 4'b0001) begin
      n_bad++; $display("FAIL wrap_write got wv=%b %h exp %h", wv, got, e);
    end
    v = '0;
    repeat (3) begin
      #1; model_push(1'b0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
      n_cmp++;
      if (got !== e || wv !== 4'b0000 || cv !== 4'b0000) begin
        n_bad++; $display("FAIL idle_hold got wv=%b %h exp %h", wv, got, e);
      end
    end
    v = 4'b1001; pr[0] = 7'h10; d[0] = 32'h0000_0A0A; rob[0] = 7'h50;
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_bad++; $display("FAIL wrap_ptr got %b exp 0001", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (got !== e || cv !== e.vld || wd[0] !== 32'h0000_0A0A) begin
      n_bad++; $display("FAIL wrap_ptr_write got %h exp %h", got, e);
    end
  endtask

  // Two stalling WB stages (req0, req1) each retire four ops to bank 1,
  // holding their payload until accepted.
  task automatic test_back_to_back();
    int ia = 0, ib = 0, cyc = 0, total = 0;
    int seen[128];
    logic acc0, acc1;
    for (int i = 0; i < 128; i++) seen[i] = 0;
    while ((ia < 4 || ib < 4) && cyc < 20) begin
      v = '0;
      if (ia < 4) begin
        v[0] = 1'b1; pr[0] = 7'(4 * ia + 1); d[0] = 32'hA000_0000 + ia; rob[0] = 7'(7'h30 + ia);
      end
      if (ib < 4) begin
        v[1] = 1'b1; pr[1] = 7'(4 * ib + 5); d[1] = 32'hB000_0000 + ib; rob[1] = 7'(7'h40 + ib);
      end
      #1; model_push(1'b0);
      n_cmp++;
      if (rdy !== m_rdy) begin
        n_bad++; $display("FAIL b2b_ready cyc%0d got %b exp %b", cyc, rdy, m_rdy);
      end
      acc0 = v[0] & rdy[0];
      acc1 = v[1] & rdy[1];
      @(posedge clk); #1;
      e = sb_q.pop_front();
      got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
      n_cmp++;
      if (got !== e || cv !== e.vld) begin
        n_bad++; $display("FAIL b2b_write cyc%0d got %h exp %h", cyc, got, e);
      end
      if (cv[1]) begin seen[crob[1]]++; total++; end
      if (acc0) ia++;
      if (acc1) ib++;
      cyc++;
    end
    n_cmp++;
    if (ia != 4 || ib != 4 || cyc != 8) begin
      n_bad++; $display("FAIL b2b_progress got a=%0d b=%0d cycles=%0d exp 4 4 8", ia, ib, cyc);
    end
    n_cmp++;
    if (total != 8) begin
      n_bad++; $display("FAIL b2b_total got %0d completes exp 8", total);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (seen[8'h30 + k] != 1 || seen[8'h40 + k] != 1) begin
        n_bad++; $display("FAIL b2b_once idx%0d got %0d/%0d exp 1/1", k, seen[8'h30 + k], seen[8'h40 + k]);
      end
    end
    v = '0;
  endtask

  task automatic test_mid_reset();
    v = 4'b0001; pr[0] = 7'h03; d[0] = 32'h5555_0000; rob[0] = 7'h60;
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_pre got %b exp 0001", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (got !== e || cv !== e.vld) begin
      n_bad++; $display("FAIL midrst_pre_write got %h exp %h", got, e);
    end
    // req2 wins bank 3, then reset arrives before the edge
    v = 4'b0100; pr[2] = 7'h07; d[2] = 32'h7777_0007; rob[2] = 7'h62;
    #1;
    n_cmp++;
    if (rdy !== 4'b0100) begin
      n_bad++; $display("FAIL midrst_grant got %b exp 0100", rdy);
    end
    rst = 1'b1;
    #1; model_push(1'b1);
    n_cmp++;
    if (rdy !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_ready got %b exp 0000", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (got !== e || wv !== 4'b0000 || cv !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_drop got wv=%b %h exp zero", wv, got);
    end
    rst = 1'b0;
    v = 4'b0011; pr[0] = 7'h03; pr[1] = 7'h0B; d[1] = 32'h6666_0001; rob[1] = 7'h61;
    #1; model_push(1'b0);
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_ptr got %b exp 0001", rdy);
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    got.vld = wv; got.pr = wpr; got.data = wd; got.rob = crob;
    n_cmp++;
    if (got !== e || cv !== e.vld || wd[3] !== 32'h5555_0000) begin
      n_bad++; $display("FAIL midrst_after got %h exp %h", got, e);
    end
    v = '0;
  endtask

  initial begin
    rst = 1'b1; v = '0; d = '0; pr = '0; rob = '0;
    @(posedge clk); #1;
    test_reset();
    test_full_conflict();
    test_parallel();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
